traffic_scheduler: RTL and testbench
====================================

Name: traffic_scheduler

Overview:
- Schedules the obstacle ("dodge") cars for the racing game.
- Owns NUM_CARS sprite slots and, once per video frame, advances each active car down the screen, retires cars that leave the bottom, and spawns new cars into pseudo-random lanes.
- Drives the car_x, car_y and enable inputs of the per-car sprite renderers.
- Sits between the frame timing (vblank pulse) and the sprite ROM blocks; reports passed-car count to the score logic.

Parameters:
- NUM_CARS, 3, number of obstacle slots (1..8)
- LANE_BITS, 2, log2 of lane count; lanes = 2**LANE_BITS
- LANE_BASE, 200, pixel column of lane 0 car left edge
- LANE_PITCH, 64, column spacing between lanes
- SCREEN_H, 480, visible rows; car retired when car_y >= SCREEN_H
- SPAWN_GAP, 96, min car_y every active car must have before a spawn is allowed
- SPAWN_FRAMES, 40, frames between spawn attempts after a successful spawn
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
- clk  in  1  system/pixel clock
- reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse at start of vblank
- run  in  1  game running; low holds all state
- clear  in  1  one-cycle pulse: disable all slots, zero counters
- collision  in  1  freeze: frame_tick ignored while high
- speed  in  3  pixels per frame added to car_y (0..7)
- car_x  out  10*NUM_CARS  packed slot columns, slot i at [10i+9:10i]
- car_y  out  10*NUM_CARS  packed slot rows
- car_en  out  NUM_CARS  slot active (renderer enable)
- passed_cnt  out  8  cars retired off bottom, saturates at 255
- busy  out  1  high while the frame update sequence runs

Behaviour:
- Reset: car_x=0, car_y=0, car_en=0, passed_cnt=0, busy=0, spawn timer=0, slot index=0, LFSR=LFSR_SEED, FSM=IDLE.
- LFSR: 16-bit Galois, taps 16,14,13,11. Advances every clock, including during IDLE; reset only by reset_n.
- FSM states: IDLE, MOVE, RETIRE, SPAWN.
- IDLE: on frame_tick with run=1 and collision=0, go to MOVE, set slot index=0, set busy=1. Otherwise frame_tick is dropped, never queued.
- MOVE: one slot per cycle. If car_en[i]=1, car_y[i] += speed, with a 10-bit add; overflow is impossible because y <= SCREEN_H-1+7. After slot NUM_CARS-1, go to RETIRE with index=0.
- RETIRE: one slot per cycle. If car_en[i]=1 and car_y[i] >= SCREEN_H, clear car_en[i] and increment passed_cnt (saturate at 255). After the last slot, go to SPAWN.
- SPAWN (1 cycle):
  - If spawn timer != 0, decrement it.
  - Else, if a free slot exists and every active slot has car_y >= SPAWN_GAP: fill the lowest-index free slot with car_en=1, car_y=0, car_x = LANE_BASE + lfsr[LANE_BITS-1:0]*LANE_PITCH, and reload the timer with SPAWN_FRAMES-1.
  - Else the timer stays 0, so the spawn is retried next frame.
  - Go to IDLE, busy=0.
- Latency: frame_tick to busy falling is 2*NUM_CARS+1 cycles after the IDLE cycle. car_x, car_y and car_en change only while busy=1, so they are stable during active video.
- clear: highest priority after reset, in any state. Sets car_en=0, car_y=0, car_x=0, passed_cnt=0, timer=0, FSM=IDLE, busy=0.
- run falling mid-sequence: the current sequence completes. run only gates new frame_tick acceptance.
- collision rising mid-sequence: the sequence completes. Subsequent ticks are ignored until collision=0.
- speed=0: cars do not move, and the spawn timer still counts.
- Simultaneous frame_tick and clear: clear wins, and the tick is dropped.

Decomposition:
- Shared package/header holds the screen constants (SCREEN_H, screen width 640), the sprite size constants (CAR_W=32, CAR_H=64) and the lane geometry defaults, also used by the renderers and collision logic.
- One sub-module: lfsr16 (clk, reset_n, seed parameter, 16-bit state out).
- Slot arrays and the FSM stay in traffic_scheduler.

Test Plan:
- Reset: hold reset_n=0 then release -> all outputs 0, busy=0; first frame_tick with run=1 -> slot0 en=1, y=0, x in {200,264,328,392}; busy high exactly 7 cycles for NUM_CARS=3.
- Motion: speed=5, one active car at y=0, 10 frame_ticks -> car_y=50; second spawn blocked until y >= 96, which occurs at tick 20 and requires the timer expired (SPAWN_FRAMES=1 in this test).
- Retire: car at y=478, speed=3 -> after tick y=481, then car_en cleared in RETIRE, passed_cnt 0->1; passed_cnt at 255 plus a retire -> stays 255.
- Freeze/run: collision=1 or run=0 with 5 ticks -> car_y, car_en and timer unchanged, busy never asserts; deassert and tick -> normal update resumes.
- Full slots: 3 cars active, all y >= 96, timer=0 -> no spawn, timer stays 0; one retires -> slot freed, spawn fills that lowest free index on the same tick.
- Clear/edge: clear asserted mid-MOVE -> next cycle all en=0, passed_cnt=0, busy=0; frame_tick asserted while busy=1 -> ignored, car_y advances once only.

Source files
------------

// File: rtl/traffic_scheduler_pkg.sv
// Shared constants for the dodge-car game: screen and sprite geometry,
// lane layout defaults, scheduler FSM states and the LFSR step function.
package traffic_scheduler_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int CAR_W         = 32;
  localparam int CAR_H         = 64;

  localparam int DEF_LANE_BITS    = 2;
  localparam int DEF_LANE_BASE    = 200;
  localparam int DEF_LANE_PITCH   = 64;
  localparam int DEF_SPAWN_GAP    = 96;
  localparam int DEF_SPAWN_FRAMES = 40;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_RETIRE,
    ST_SPAWN
  } sched_state_e;

  // Right-shifting Galois form of the x^16+x^14+x^13+x^11+1 polynomial
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

endpackage

// File: rtl/traffic_scheduler_if.sv
// Control and sprite-slot bus between the game logic and the traffic scheduler.
interface traffic_scheduler_if #(
  parameter int NUM_CARS = 3
);

  logic                    frame_tick;
  logic                    run;
  logic                    clear;
  logic                    collision;
  logic [2:0]              speed;
  logic [10*NUM_CARS-1:0]  car_x;
  logic [10*NUM_CARS-1:0]  car_y;
  logic [NUM_CARS-1:0]     car_en;
  logic [7:0]              passed_cnt;
  logic                    busy;

  modport master (
    output frame_tick, run, clear, collision, speed,
    input  car_x, car_y, car_en, passed_cnt, busy
  );

  modport slave (
    input  frame_tick, run, clear, collision, speed,
    output car_x, car_y, car_en, passed_cnt, busy
  );

endinterface

// File: rtl/traffic_scheduler_lfsr16.sv
// Free-running 16-bit Galois LFSR used to pick spawn lanes.
module lfsr16
  import traffic_scheduler_pkg::*;
#(
  parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = lfsr_next(state_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/traffic_scheduler.sv
// Per-frame obstacle car scheduler: moves, retires and spawns cars in
// NUM_CARS sprite slots, one slot per clock, after each accepted vblank tick.
module traffic_scheduler
  import traffic_scheduler_pkg::*;
#(
  parameter int          NUM_CARS     = 3,
  parameter int          LANE_BITS    = DEF_LANE_BITS,
  parameter int          LANE_BASE    = DEF_LANE_BASE,
  parameter int          LANE_PITCH   = DEF_LANE_PITCH,
  parameter int          SCREEN_H     = SCREEN_HEIGHT,
  parameter int          SPAWN_GAP    = DEF_SPAWN_GAP,
  parameter int          SPAWN_FRAMES = DEF_SPAWN_FRAMES,
  parameter logic [15:0] LFSR_SEED    = DEF_LFSR_SEED
) (
  input  logic                clk,
  input  logic                reset_n,
  traffic_scheduler_if.slave  bus
);

  localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
  localparam int TMR_W = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CARS - 1);
  localparam logic [TMR_W-1:0] TIMER_RELOAD = TMR_W'(SPAWN_FRAMES - 1);

  sched_state_e         state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [7:0]           passed_q, passed_d;
  logic                 busy_q, busy_d;
  logic [NUM_CARS-1:0]  en_q, en_d;
  logic [9:0]           x_q [NUM_CARS];
  logic [9:0]           x_d [NUM_CARS];
  logic [9:0]           y_q [NUM_CARS];
  logic [9:0]           y_d [NUM_CARS];

  logic [15:0]          lfsr_state;
  logic [9:0]           lane_x;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic                 gap_ok;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .state   (lfsr_state)
  );

  assign lane_x = 10'(LANE_BASE) + 10'(LANE_PITCH) * 10'(lfsr_state[LANE_BITS-1:0]);

  // Lowest free slot wins; a spawn is held off until every live car is far enough down
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    gap_ok     = 1'b1;
    for (int i = NUM_CARS - 1; i >= 0; i--) begin
      if (!en_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_CARS; i++) begin
      if (en_q[i] && (y_q[i] < 10'(SPAWN_GAP))) begin
        gap_ok = 1'b0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    passed_d = passed_q;
    busy_d   = busy_q;
    en_d     = en_q;
    x_d      = x_q;
    y_d      = y_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.frame_tick && bus.run && !bus.collision) begin
          state_d = ST_MOVE;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_MOVE: begin
        if (en_q[idx_q]) begin
          y_d[idx_q] = y_q[idx_q] + {7'd0, bus.speed};
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_RETIRE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_RETIRE: begin
        if (en_q[idx_q] && (y_q[idx_q] >= 10'(SCREEN_H))) begin
          en_d[idx_q] = 1'b0;
          if (passed_q != 8'hFF) begin
            passed_d = passed_q + 8'd1;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_SPAWN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_SPAWN: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (free_found && gap_ok) begin
          en_d[free_idx] = 1'b1;
          y_d[free_idx]  = 10'd0;
          x_d[free_idx]  = lane_x;
          timer_d        = TIMER_RELOAD;
        end
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Clear overrides whatever the sequence was doing, including a same-cycle tick
    if (bus.clear) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      timer_d  = '0;
      passed_d = 8'd0;
      busy_d   = 1'b0;
      en_d     = '0;
      for (int i = 0; i < NUM_CARS; i++) begin
        x_d[i] = 10'd0;
        y_d[i] = 10'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      timer_q  <= '0;
      passed_q <= 8'd0;
      busy_q   <= 1'b0;
      en_q     <= '0;
      for (int i = 0; i < NUM_CARS; i++) begin
        x_q[i] <= 10'd0;
        y_q[i] <= 10'd0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      passed_q <= passed_d;
      busy_q   <= busy_d;
      en_q     <= en_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  for (genvar g = 0; g < NUM_CARS; g++) begin : g_pack
    assign bus.car_x[10*g +: 10] = x_q[g];
    assign bus.car_y[10*g +: 10] = y_q[g];
  end

  assign bus.car_en     = en_q;
  assign bus.passed_cnt = passed_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_traffic_scheduler.sv
// Scoreboard bench for traffic_scheduler: a frame-level reference model
// predicts slot state per accepted tick; a monitor compares when busy falls.
module tb_traffic_scheduler;

  localparam int NC = 3;
  localparam int SF = 3;
  localparam int SEQ_LEN = 2 * NC + 1;

  typedef struct packed {
    logic [10*NC-1:0] x;
    logic [10*NC-1:0] y;
    logic [NC-1:0]    en;
    logic [7:0]       passed;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  traffic_scheduler_if #(.NUM_CARS(NC)) bus ();

  traffic_scheduler #(
    .NUM_CARS     (NC),
    .SPAWN_FRAMES (SF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];
  logic abort_ok = 1'b0;

  logic [9:0]  m_x [NC];
  logic [9:0]  m_y [NC];
  logic        m_en [NC];
  int          m_passed;
  int          m_timer;
  int          m_retired;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0];
    s  = s >> 1;
    if (fb) s = s ^ 16'hB400;
    return s;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) begin
      m_x[i] = 10'd0;
      m_y[i] = 10'd0;
      m_en[i] = 1'b0;
    end
    m_passed = 0;
    m_timer  = 0;
  endfunction

  function automatic exp_t model_snap();
    exp_t e;
    for (int i = 0; i < NC; i++) begin
      e.x[10*i +: 10] = m_x[i];
      e.y[10*i +: 10] = m_y[i];
      e.en[i]         = m_en[i];
    end
    e.passed = 8'(m_passed);
    return e;
  endfunction

  function automatic void model_frame(input logic [15:0] lf, input logic [2:0] spd);
    int  free;
    bit  gap;
    for (int i = 0; i < NC; i++)
      if (m_en[i]) m_y[i] = m_y[i] + 10'(spd);
    for (int i = 0; i < NC; i++) begin
      if (m_en[i] && m_y[i] >= 10'd480) begin
        m_en[i] = 1'b0;
        m_retired++;
        if (m_passed < 255) m_passed++;
      end
    end
    if (m_timer != 0) begin
      m_timer--;
    end else begin
      free = -1;
      for (int i = NC - 1; i >= 0; i--)
        if (!m_en[i]) free = i;
      gap = 1'b1;
      for (int i = 0; i < NC; i++)
        if (m_en[i] && m_y[i] < 10'd96) gap = 1'b0;
      if (free >= 0 && gap) begin
        m_en[free] = 1'b1;
        m_y[free]  = 10'd0;
        m_x[free]  = 10'(200 + int'(lf[1:0]) * 64);
        m_timer    = SF - 1;
      end
    end
  endfunction

  // Monitor: each completed update sequence is compared against the oldest prediction
  initial begin
    int   busy_len;
    logic busy_prev;
    exp_t e;
    busy_len  = 0;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        busy_len++;
      end else if (busy_prev) begin
        if (abort_ok) begin
          abort_ok = 1'b0;
        end else begin
          n_checks++;
          if (busy_len != SEQ_LEN) begin
            n_fail++;
            $display("[TB] FAIL busy_len: got %0d cycles, want %0d", busy_len, SEQ_LEN);
          end
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL unexpected_seq: busy pulse with no pending prediction at %0t", $time);
          end else begin
            e = sb.pop_front();
            n_checks++;
            if (bus.car_en !== e.en) begin
              n_fail++;
              $display("[TB] FAIL car_en: got %b, want %b at %0t", bus.car_en, e.en, $time);
            end
            n_checks++;
            if (bus.car_y !== e.y) begin
              n_fail++;
              $display("[TB] FAIL car_y: got %h, want %h at %0t", bus.car_y, e.y, $time);
            end
            n_checks++;
            if (bus.car_x !== e.x) begin
              n_fail++;
              $display("[TB] FAIL car_x: got %h, want %h at %0t", bus.car_x, e.x, $time);
            end
            n_checks++;
            if (bus.passed_cnt !== e.passed) begin
              n_fail++;
              $display("[TB] FAIL passed_cnt: got %0d, want %0d at %0t", bus.passed_cnt, e.passed, $time);
            end
          end
        end
        busy_len = 0;
      end
      busy_prev = (bus.busy === 1'b1);
    end
  end

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while (bus.busy !== 1'b0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.busy !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: busy=%b after %0d cycles, want 0", tag, bus.busy, cyc);
    end
  endtask

  task automatic push_prediction();
    logic [15:0] lf;
    lf = m_lfsr;
    repeat (SEQ_LEN) lf = lfsr_step(lf);
    model_frame(lf, bus.speed);
    sb.push_back(model_snap());
  endtask

  task automatic send_tick();
    bit acc;
    acc = bus.run && !bus.collision;
    bus.frame_tick = 1'b1;
    if (acc) push_prediction();
    @(negedge clk);
    bus.frame_tick = 1'b0;
    wait_idle("tick");
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    model_reset();
    m_retired = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.car_en !== '0) begin n_fail++; $display("[TB] FAIL reset_en: got %b, want 0", bus.car_en); end
    n_checks++; if (bus.car_y !== '0) begin n_fail++; $display("[TB] FAIL reset_y: got %h, want 0", bus.car_y); end
    n_checks++; if (bus.car_x !== '0) begin n_fail++; $display("[TB] FAIL reset_x: got %h, want 0", bus.car_x); end
    n_checks++; if (bus.passed_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_passed: got %0d, want 0", bus.passed_cnt); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b, want 0", bus.busy); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_busy: got %b, want 0", bus.busy); end
  endtask

  task automatic test_first_spawn();
    logic [9:0] x0;
    bus.run   = 1'b1;
    bus.speed = 3'd5;
    send_tick();
    x0 = bus.car_x[9:0];
    n_checks++; if (bus.car_en !== 3'b001) begin n_fail++; $display("[TB] FAIL first_en: got %b, want 001", bus.car_en); end
    n_checks++; if (bus.car_y[9:0] !== 10'd0) begin n_fail++; $display("[TB] FAIL first_y: got %0d, want 0", bus.car_y[9:0]); end
    n_checks++;
    if (!(x0 == 10'd200 || x0 == 10'd264 || x0 == 10'd328 || x0 == 10'd392)) begin
      n_fail++;
      $display("[TB] FAIL first_lane: got %0d, want one of 200/264/328/392", x0);
    end
  endtask

  task automatic test_motion();
    repeat (10) send_tick();
    n_checks++; if (bus.car_y[9:0] !== 10'd50) begin n_fail++; $display("[TB] FAIL motion_y50: got %0d, want 50", bus.car_y[9:0]); end
    repeat (9) send_tick();
    n_checks++; if (bus.car_y[9:0] !== 10'd95) begin n_fail++; $display("[TB] FAIL motion_y95: got %0d, want 95", bus.car_y[9:0]); end
    n_checks++; if (bus.car_en[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL gap_block: en1=%b, want 0", bus.car_en[1]); end
    send_tick();
    n_checks++; if (bus.car_en[1] !== 1'b1) begin n_fail++; $display("[TB] FAIL gap_spawn: en1=%b, want 1", bus.car_en[1]); end
    n_checks++; if (bus.car_y[19:10] !== 10'd0) begin n_fail++; $display("[TB] FAIL gap_spawn_y: got %0d, want 0", bus.car_y[19:10]); end
  endtask

  task automatic test_freeze();
    logic [10*NC-1:0] sy;
    logic [NC-1:0]    se;
    sy = bus.car_y;
    se = bus.car_en;
    bus.collision = 1'b1;
    repeat (5) send_tick();
    n_checks++; if (bus.car_y !== sy) begin n_fail++; $display("[TB] FAIL collision_y: got %h, want %h", bus.car_y, sy); end
    n_checks++; if (bus.car_en !== se) begin n_fail++; $display("[TB] FAIL collision_en: got %b, want %b", bus.car_en, se); end
    bus.collision = 1'b0;
    bus.run       = 1'b0;
    repeat (5) send_tick();
    n_checks++; if (bus.car_y !== sy) begin n_fail++; $display("[TB] FAIL run_low_y: got %h, want %h", bus.car_y, sy); end
    bus.run = 1'b1;
    send_tick();
    n_checks++; if (bus.car_y[9:0] !== 10'd105) begin n_fail++; $display("[TB] FAIL resume_y: got %0d, want 105", bus.car_y[9:0]); end
  endtask

  task automatic test_speed_zero();
    logic [10*NC-1:0] sy;
    bus.speed = 3'd0;
    sy = bus.car_y;
    repeat (3) send_tick();
    n_checks++; if (bus.car_y !== sy) begin n_fail++; $display("[TB] FAIL speed0_y: got %h, want %h", bus.car_y, sy); end
  endtask

  task automatic test_retire_saturate();
    int r0;
    bus.speed = 3'd6;
    for (int k = 0; k < 1500 && m_retired < 2; k++) send_tick();
    bus.speed = 3'd7;
    for (int k = 0; k < 9000 && m_passed < 255; k++) send_tick();
    n_checks++; if (bus.passed_cnt !== 8'd255) begin n_fail++; $display("[TB] FAIL passed_255: got %0d, want 255", bus.passed_cnt); end
    r0 = m_retired;
    for (int k = 0; k < 300 && m_retired == r0; k++) send_tick();
    n_checks++; if (bus.passed_cnt !== 8'd255) begin n_fail++; $display("[TB] FAIL passed_sat: got %0d, want 255", bus.passed_cnt); end
  endtask

  task automatic test_run_drop();
    bus.speed = 3'd4;
    bus.frame_tick = 1'b1;
    push_prediction();
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(negedge clk);
    bus.run = 1'b0;
    wait_idle("run_drop");
    n_checks++;
    if (bus.car_y !== model_snap().y) begin
      n_fail++;
      $display("[TB] FAIL run_drop_y: got %h, want %h", bus.car_y, model_snap().y);
    end
    bus.run = 1'b1;
  endtask

  task automatic test_clear_mid_move();
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.clear      = 1'b1;
    abort_ok       = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    model_reset();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_busy: got %b, want 0", bus.busy); end
    n_checks++; if (bus.car_en !== '0) begin n_fail++; $display("[TB] FAIL clear_en: got %b, want 0", bus.car_en); end
    n_checks++; if (bus.passed_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL clear_passed: got %0d, want 0", bus.passed_cnt); end
    n_checks++; if (bus.car_y !== '0) begin n_fail++; $display("[TB] FAIL clear_y: got %h, want 0", bus.car_y); end
    n_checks++; if (bus.car_x !== '0) begin n_fail++; $display("[TB] FAIL clear_x: got %h, want 0", bus.car_x); end
  endtask

  task automatic test_tick_with_clear();
    bit seen;
    bus.frame_tick = 1'b1;
    bus.clear      = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.clear      = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      if (bus.busy !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (seen) begin n_fail++; $display("[TB] FAIL tick_clear_busy: busy asserted, want 0"); end
    n_checks++; if (bus.car_en !== '0) begin n_fail++; $display("[TB] FAIL tick_clear_en: got %b, want 0", bus.car_en); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    bus.speed = 3'd3;
    send_tick();
    bus.frame_tick = 1'b1;
    push_prediction();
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    wait_idle("b2b");
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("[TB] FAIL b2b_queued: busy reasserted, want 0"); end
    n_checks++; if (bus.car_y[9:0] !== 10'd3) begin n_fail++; $display("[TB] FAIL b2b_y: got %0d, want 3", bus.car_y[9:0]); end
  endtask

  initial begin
    reset_n        = 1'b1;
    bus.frame_tick = 1'b0;
    bus.run        = 1'b0;
    bus.clear      = 1'b0;
    bus.collision  = 1'b0;
    bus.speed      = 3'd0;
    test_reset();
    test_first_spawn();
    test_motion();
    test_freeze();
    test_speed_zero();
    test_retire_saturate();
    test_run_drop();
    test_clear_mid_move();
    test_tick_with_clear();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL sb_drain: %0d predictions left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
